ram_loader: RTL and testbench

- Program-loader FSM directly upstream of the RAM/MAR block.
- Accepts a byte stream over a valid/ready handshake and writes it into consecutive RAM addresses starting at 0. It drives the RAM's manual address, manual data, program-mode select, MAR load and write-enable lines.
- Replaces hand-toggling of dipswitches during program entry. The bus path is untouched.

---
 rtl/ram_loader.sv | 154 +++++++++++++++
 tb/tb_ram_loader.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_loader.sv
// Program loader: writes a valid/ready byte stream into consecutive RAM addresses from 0,
// driving the RAM's manual address/data, program-mode, MAR load and write-enable lines.
module ram_loader #(
   parameter int unsigned ADDR_WIDTH = 4,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned WE_CYCLES  = 2
) (
   input  logic                  clk,
   input  logic                  clear_n,
   input  logic                  start,
   input  logic [ADDR_WIDTH:0]   num_bytes,
   input  logic                  abort,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_data,
   output logic                  ram_prog_mode,
   output logic                  ram_load_addr_n,
   output logic                  ram_we_n,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_WIDTH:0]   byte_count
);

   localparam int unsigned CntW = (WE_CYCLES > 1) ? $clog2(WE_CYCLES) : 1;
   localparam logic [CntW-1:0] WeLast = CntW'(WE_CYCLES - 1);
   localparam logic [ADDR_WIDTH:0] MaxCount = {1'b1, {ADDR_WIDTH{1'b0}}};

   // One-hot so every RAM strobe is a single flop bit.
   typedef enum logic [5:0] {
      StIdle     = 6'b000001,
      StWaitByte = 6'b000010,
      StSetup    = 6'b000100,
      StWrite    = 6'b001000,
      StHold     = 6'b010000,
      StDone     = 6'b100000
   } state_e;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic [ADDR_WIDTH:0]   count_q, count_d;
   logic [ADDR_WIDTH:0]   target_q, target_d;
   logic [CntW-1:0]       we_cnt_q, we_cnt_d;
   logic                  abort_q, abort_d;
   logic [ADDR_WIDTH:0]   target_clamp;

   assign target_clamp = (num_bytes > MaxCount) ? MaxCount : num_bytes;

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      data_d   = data_q;
      count_d  = count_q;
      target_d = target_q;
      we_cnt_d = we_cnt_q;
      abort_d  = abort_q;

      unique case (state_q)
         StIdle: begin
            if (start && !abort) begin
               count_d  = '0;
               addr_d   = '0;
               target_d = target_clamp;
               abort_d  = 1'b0;
               state_d  = (target_clamp == '0) ? StDone : StWaitByte;
            end
         end
         StWaitByte: begin
            if (abort) begin
               state_d = StIdle;
            end else if (in_valid) begin
               data_d  = in_data;
               state_d = StSetup;
            end
         end
         StSetup: begin
            if (abort) begin
               state_d = StIdle;
            end else begin
               we_cnt_d = WeLast;
               state_d  = StWrite;
            end
         end
         StWrite: begin
            // An abort here only takes effect once the write pulse has finished.
            if (abort) begin
               abort_d = 1'b1;
            end
            if (we_cnt_q == '0) begin
               state_d = StHold;
            end else begin
               we_cnt_d = we_cnt_q - 1'b1;
            end
         end
         StHold: begin
            count_d = count_q + 1'b1;
            abort_d = 1'b0;
            if (abort || abort_q) begin
               state_d = StIdle;
            end else if (count_d == target_q) begin
               addr_d  = '0;
               state_d = StDone;
            end else begin
               addr_d  = addr_q + 1'b1;
               state_d = StWaitByte;
            end
         end
         StDone: begin
            addr_d  = '0;
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Async clear drops the state straight to idle, releasing ram_we_n without a clock edge.
   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         state_q  <= StIdle;
         addr_q   <= '0;
         data_q   <= '0;
         count_q  <= '0;
         target_q <= '0;
         we_cnt_q <= '0;
         abort_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
         count_q  <= count_d;
         target_q <= target_d;
         we_cnt_q <= we_cnt_d;
         abort_q  <= abort_d;
      end
   end

   always_comb begin
      in_ready        = (state_q == StWaitByte);
      ram_prog_mode   = (state_q == StIdle) || (state_q == StDone);
      ram_load_addr_n = (state_q != StSetup);
      ram_we_n        = (state_q != StWrite);
      busy            = (state_q != StIdle);
      done            = (state_q == StDone);
   end

   assign ram_addr   = addr_q;
   assign ram_data   = data_q;
   assign byte_count = count_q;

endmodule

// File: tb/tb_ram_loader.sv
// Directed bench for ram_loader: RAM/MAR model, write-pulse monitor and immediate assertions.
module tb_ram_loader;

   localparam int unsigned AW = 4;
   localparam int unsigned DW = 8;

   logic          clk = 1'b0;
   logic          clear_n = 1'b0;
   logic          start = 1'b0;
   logic [AW:0]   num_bytes = '0;
   logic          abort = 1'b0;
   logic [DW-1:0] in_data;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_data;
   logic          ram_prog_mode;
   logic          ram_load_addr_n;
   logic          ram_we_n;
   logic          busy;
   logic          done;
   logic [AW:0]   byte_count;

   ram_loader #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .WE_CYCLES  (2)
   ) dut (
      .clk             (clk),
      .clear_n         (clear_n),
      .start           (start),
      .num_bytes       (num_bytes),
      .abort           (abort),
      .in_data         (in_data),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .ram_addr        (ram_addr),
      .ram_data        (ram_data),
      .ram_prog_mode   (ram_prog_mode),
      .ram_load_addr_n (ram_load_addr_n),
      .ram_we_n        (ram_we_n),
      .busy            (busy),
      .done            (done),
      .byte_count      (byte_count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // Stream source and RAM/MAR model.
   logic [7:0] stream [16];
   logic [7:0] mem [16] = '{default: 8'h5A};
   logic [3:0] mar = '0;
   int hs_n = 0;
   int hs_base = 0;
   int cyc = 0;

   assign in_data = stream[4'(hs_n - hs_base)];

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (in_valid && in_ready) hs_n <= hs_n + 1;
      if (!ram_load_addr_n) mar <= ram_addr;
      if (!ram_we_n && !ram_prog_mode) mem[mar] <= ram_data;
   end

   // Write-pulse monitor, sampled mid-cycle.
   int wr_n = 0;
   int done_n = 0;
   int unstable = 0;
   int wr_addr [64];
   int wr_data [64];
   int wr_len [64];
   int wr_cyc [64];
   logic we_prev = 1'b1;

   always @(negedge clk) begin
      if (!ram_we_n) begin
         if (we_prev) begin
            if (wr_n < 64) begin
               wr_addr[wr_n] = int'(ram_addr);
               wr_data[wr_n] = int'(ram_data);
               wr_cyc[wr_n]  = cyc;
               wr_len[wr_n]  = 1;
            end
            wr_n++;
         end else if (wr_n > 0 && wr_n <= 64) begin
            wr_len[wr_n-1]++;
            if (wr_addr[wr_n-1] != int'(ram_addr) || wr_data[wr_n-1] != int'(ram_data))
               unstable++;
         end
      end
      if (done) done_n++;
      we_prev = ram_we_n;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start(input logic [AW:0] nb);
      num_bytes = nb;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget, output bit seen);
      seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         tick();
         if (done) seen = 1'b1;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int wb, db;
      bit seen;

      // 1. Reset values, then clear during a write.
      repeat (3) tick();
      chk("rst_we_n_held", ram_we_n, 1);
      clear_n = 1'b1;
      tick();
      chk("rst_in_ready", in_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_we_n", ram_we_n, 1);
      chk("rst_load_addr_n", ram_load_addr_n, 1);
      chk("rst_prog_mode", ram_prog_mode, 1);
      chk("rst_ram_addr", ram_addr, 0);
      chk("rst_ram_data", ram_data, 0);
      chk("rst_byte_count", byte_count, 0);

      stream[0] = 8'hAA;
      hs_base = hs_n;
      in_valid = 1'b1;
      pulse_start(5'd1);
      tick();
      tick();
      chk("midwr_we_low", ram_we_n, 0);
      #2 clear_n = 1'b0;
      #1;
      chk("midwr_we_async_high", ram_we_n, 1);
      chk("midwr_busy", busy, 0);
      chk("midwr_prog_mode", ram_prog_mode, 1);
      #2 clear_n = 1'b1;
      in_valid = 1'b0;
      tick();
      chk("midwr_idle_after", busy, 0);

      // 2. Three bytes with in_valid held high.
      stream[0] = 8'hCF; stream[1] = 8'hF7; stream[2] = 8'h01;
      hs_base = hs_n; wb = wr_n; db = done_n;
      in_valid = 1'b1;
      pulse_start(5'd3);
      wait_done(40, seen);
      chk("t2_done_seen", seen, 1);
      tick(); tick();
      in_valid = 1'b0;
      chk("t2_writes", wr_n - wb, 3);
      chk("t2_addr0", wr_addr[wb], 0);
      chk("t2_addr1", wr_addr[wb+1], 1);
      chk("t2_addr2", wr_addr[wb+2], 2);
      chk("t2_data0", wr_data[wb], 32'hCF);
      chk("t2_data1", wr_data[wb+1], 32'hF7);
      chk("t2_data2", wr_data[wb+2], 32'h01);
      chk("t2_len0", wr_len[wb], 2);
      chk("t2_len2", wr_len[wb+2], 2);
      chk("t2_gap01", wr_cyc[wb+1] - wr_cyc[wb], 5);
      chk("t2_gap12", wr_cyc[wb+2] - wr_cyc[wb+1], 5);
      chk("t2_done_once", done_n - db, 1);
      chk("t2_byte_count", byte_count, 3);
      chk("t2_mem0", mem[0], 8'hCF);
      chk("t2_mem1", mem[1], 8'hF7);
      chk("t2_mem2", mem[2], 8'h01);

      // 3. Backpressure gaps before and between bytes.
      stream[0] = 8'h11; stream[1] = 8'h22;
      hs_base = hs_n; wb = wr_n; db = done_n;
      in_valid = 1'b0;
      pulse_start(5'd2);
      for (int i = 0; i < 4; i++) begin
         chk("t3_gap0_ready", in_ready, 1);
         tick();
      end
      chk("t3_gap0_nowrite", wr_n - wb, 0);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (4) tick();
      chk("t3_one_write", wr_n - wb, 1);
      for (int i = 0; i < 4; i++) begin
         chk("t3_gap1_ready", in_ready, 1);
         chk("t3_gap1_we_n", ram_we_n, 1);
         tick();
      end
      chk("t3_gap1_nowrite", wr_n - wb, 1);
      in_valid = 1'b1;
      wait_done(20, seen);
      chk("t3_done_seen", seen, 1);
      tick();
      in_valid = 1'b0;
      chk("t3_writes", wr_n - wb, 2);
      chk("t3_byte_count", byte_count, 2);
      chk("t3_mem0", mem[0], 8'h11);
      chk("t3_mem1", mem[1], 8'h22);

      // 5. Abort during the write of byte 2 (address 1).
      stream[0] = 8'h33; stream[1] = 8'h44; stream[2] = 8'h55;
      hs_base = hs_n; wb = wr_n; db = done_n;
      in_valid = 1'b1;
      pulse_start(5'd3);
      for (int i = 0; i < 30 && !(ram_we_n == 1'b0 && ram_addr == 4'd1); i++) tick();
      chk("t5_reach_write1", {ram_we_n, ram_addr}, {1'b0, 4'd1});
      abort = 1'b1;
      tick();
      abort = 1'b0;
      for (int i = 0; i < 10 && busy; i++) tick();
      in_valid = 1'b0;
      chk("t5_busy_dropped", busy, 0);
      chk("t5_no_done", done_n - db, 0);
      chk("t5_byte_count", byte_count, 2);
      chk("t5_writes", wr_n - wb, 2);
      chk("t5_last_len", wr_len[wb+1], 2);
      chk("t5_mem0", mem[0], 8'h33);
      chk("t5_mem1", mem[1], 8'h44);
      chk("t5_mem2_kept", mem[2], 8'h01);

      // start and abort together in idle: abort wins.
      num_bytes = 5'd3;
      start = 1'b1;
      abort = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      chk("t5_start_abort_idle", busy, 0);

      // 4a. Zero-length load.
      wb = wr_n; db = done_n;
      pulse_start(5'd0);
      seen = done;
      if (!seen) begin
         tick();
         seen = done;
      end
      chk("t4_zero_done", seen, 1);
      tick(); tick();
      chk("t4_zero_idle", busy, 0);
      chk("t4_zero_nowrite", wr_n - wb, 0);
      chk("t4_zero_done_once", done_n - db, 1);
      chk("t4_zero_count", byte_count, 0);

      // 4b. Oversized request clamps to 16 bytes.
      for (int i = 0; i < 16; i++) stream[i] = 8'(8'hA0 + i * 3);
      hs_base = hs_n; wb = wr_n; db = done_n;
      in_valid = 1'b1;
      pulse_start(5'd20);
      wait_done(120, seen);
      chk("t4_full_done_seen", seen, 1);
      chk("t4_full_addr_done", ram_addr, 0);
      tick();
      in_valid = 1'b0;
      chk("t4_full_addr_after", ram_addr, 0);
      chk("t4_full_count", byte_count, 16);
      chk("t4_full_idle", busy, 0);
      chk("t4_full_writes", wr_n - wb, 16);
      for (int i = 0; i < 16; i++) begin
         chk("t4_full_addr", wr_addr[wb+i], i);
         chk("t4_full_data", wr_data[wb+i], 32'(8'(8'hA0 + i * 3)));
         chk("t4_full_mem", mem[i], 8'(8'hA0 + i * 3));
      end

      // 6. start while busy is ignored.
      stream[0] = 8'h66; stream[1] = 8'h77;
      hs_base = hs_n; wb = wr_n; db = done_n;
      in_valid = 1'b1;
      pulse_start(5'd2);
      tick();
      pulse_start(5'd9);
      chk("t6_busy", busy, 1);
      chk("t6_addr_kept", ram_addr, 0);
      chk("t6_count_kept", byte_count, 0);
      wait_done(30, seen);
      chk("t6_done_seen", seen, 1);
      repeat (10) tick();
      in_valid = 1'b0;
      chk("t6_idle", busy, 0);
      chk("t6_writes", wr_n - wb, 2);
      chk("t6_byte_count", byte_count, 2);
      chk("t6_mem0", mem[0], 8'h66);
      chk("t6_mem1", mem[1], 8'h77);

      chk("stable_during_we", unstable, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
